// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit.
//   - op encoding (SLL / SRL / SRA; code 2'b11 behaves as SRL)
//   - datapath width, shift-amount width, stage count
//   - stage_dist(): shift distance of pipeline stage k (1..5) = 16,8,4,2,1
//   - bit_rev(): 32-bit bit reversal used to turn left shifts into right shifts
package shift_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned NUM_STAGES = 5;

  typedef enum logic [1:0] {
    OP_SLL     = 2'b00,
    OP_SRL     = 2'b01,
    OP_SRA     = 2'b10,
    OP_SRL_ALT = 2'b11
  } shift_op_e;

  // Stage k shifts by 2^(5-k): 16, 8, 4, 2, 1.
  function automatic int unsigned stage_dist(input int unsigned k);
    return 32'd16 >> (k - 1);
  endfunction

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = x[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One stage of the shift pipeline: a single 2:1 mux layer followed by a
// pipeline register.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears everything)
//   flush           clears the valid bit only; payload registers hold
//   en_i            advance enable for this stage; when low every field holds
//   valid_i..tag_i  upstream payload (valid already qualified by the transfer)
//   valid_o..tag_o  registered payload for the next stage
// Handshake: the stage loads whenever en_i is high. en_i is high when the
// stage is empty or its content is leaving this same cycle.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned DIST  = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               fill_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               left_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               valid_o,
  output logic [DATA_W-1:0]  data_o,
  output logic               fill_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output logic               left_o,
  output logic [TAG_W-1:0]   tag_o
);

  localparam int unsigned SEL_BIT = $clog2(DIST);

  logic               valid_q;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               fill_q;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               left_q;
  logic [TAG_W-1:0]   tag_q;

  // Vacated MSBs take the fill bit captured at the pipe input.
  always_comb begin
    data_d = data_i;
    if (shamt_i[SEL_BIT]) begin
      data_d = {{DIST{fill_i}}, data_i[DATA_W-1:DIST]};
    end
    // Clear the consumed bit so the register holds only the remaining amount.
    shamt_d = shamt_i & ~(SHAMT_W'(1) << SEL_BIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      shamt_q <= '0;
      left_q  <= 1'b0;
      tag_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      fill_q  <= fill_i;
      shamt_q <= shamt_d;
      left_q  <= left_i;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign fill_o  = fill_q;
  assign shamt_o = shamt_q;
  assign left_o  = left_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// Five-stage pipelined 32-bit shifter (SLL / SRL / SRA) with valid/ready on
// both sides.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   flush                          squashes all in-flight ops, blocks input
//   in_valid/in_ready              input handshake
//   in_data, in_shamt, in_op, in_tag   operation
//   out_valid/out_ready            output handshake
//   out_data, out_tag              result and its tag
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a presented payload holds stable until it transfers, and ready
// may depend combinationally on the downstream ready.
// Left shifts are done as rev(rev(x) >> s) so every stage only shifts right.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag
);

  // Index 0 is the input path, 1..5 are the stage registers.
  logic               v_w [0:NUM_STAGES];
  logic [DATA_W-1:0]  d_w [0:NUM_STAGES];
  logic               f_w [0:NUM_STAGES];
  logic [SHAMT_W-1:0] s_w [0:NUM_STAGES];
  logic               l_w [0:NUM_STAGES];
  logic [TAG_W-1:0]   t_w [0:NUM_STAGES];

  logic [NUM_STAGES+1:1] adv;
  logic                  op_left;
  logic                  op_sra;

  // Advance chain: a stage may load when empty or when its content moves on.
  always_comb begin
    adv = '0;
    adv[NUM_STAGES+1] = out_ready;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      adv[k] = !v_w[k] || adv[k+1];
    end
  end

  assign in_ready = adv[1] && !flush && !rst;

  assign op_left = (shift_op_e'(in_op) == OP_SLL);
  assign op_sra  = (shift_op_e'(in_op) == OP_SRA);

  // Fill is chosen from the unreversed operand; SLL always fills with zero.
  assign v_w[0] = in_valid && in_ready;
  assign d_w[0] = op_left ? bit_rev(in_data) : in_data;
  assign f_w[0] = op_sra & in_data[DATA_W-1];
  assign s_w[0] = in_shamt;
  assign l_w[0] = op_left;
  assign t_w[0] = in_tag;

  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stage
    shift_stage #(
      .DIST  (stage_dist(k)),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .en_i    (adv[k]),
      .valid_i (v_w[k-1]),
      .data_i  (d_w[k-1]),
      .fill_i  (f_w[k-1]),
      .shamt_i (s_w[k-1]),
      .left_i  (l_w[k-1]),
      .tag_i   (t_w[k-1]),
      .valid_o (v_w[k]),
      .data_o  (d_w[k]),
      .fill_o  (f_w[k]),
      .shamt_o (s_w[k]),
      .left_o  (l_w[k]),
      .tag_o   (t_w[k])
    );
  end

  assign out_valid = v_w[NUM_STAGES];
  assign out_data  = l_w[NUM_STAGES] ? bit_rev(d_w[NUM_STAGES]) : d_w[NUM_STAGES];
  assign out_tag   = t_w[NUM_STAGES];

  // Fill and remaining shamt are fully consumed by the last stage.
  logic unused_tail;
  assign unused_tail = f_w[NUM_STAGES] ^ (^s_w[NUM_STAGES]);

endmodule
